dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 256×8 data memory. It sits between the CPU core's load/store port and a host port; the host port is used for preload and readback around a program run. Requests are serialised through a three-state FSM with registered address and data. A starvation counter guarantees the host a slot while the CPU is busy.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arb_stats.sv | 36 +++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and defaults for the data-memory arbiter slice.
//   - arb_state_t : sequencer states IDLE / XFER / ACK
//   - owner_t     : which port owns the current transfer
//   - *_DEF       : default ADDR_W / DATA_W / MAX_WAIT values
//   - sat_inc16   : 16-bit increment that sticks at 16'hFFFF
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// dmem_arb_stats
//   Three saturating 16-bit event counters for the arbiter.
//   Ports:
//     clk, reset          : clock, asynchronous active-low reset
//     cpu_grant           : strobe, CPU granted a transfer this cycle
//     host_grant          : strobe, host granted a transfer this cycle
//     host_stall          : strobe, host was requesting but the CPU won
//     cpu_grants          : count of cpu_grant strobes
//     host_grants         : count of host_grant strobes
//     host_stall_cycles   : count of host_stall strobes
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_grant,
    input  logic        host_grant,
    input  logic        host_stall,
    output logic [15:0] cpu_grants,
    output logic [15:0] host_grants,
    output logic [15:0] host_stall_cycles
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_grants        <= 16'd0;
            host_grants       <= 16'd0;
            host_stall_cycles <= 16'd0;
        end else begin
            if (cpu_grant)  cpu_grants        <= sat_inc16(cpu_grants);
            if (host_grant) host_grants       <= sat_inc16(host_grants);
            if (host_stall) host_stall_cycles <= sat_inc16(host_stall_cycles);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter/sequencer for the shared data memory. CPU load/store
//   port and host (preload/readback) port are serialised through a
//   three-state FSM (IDLE -> XFER -> ACK) with one registered hold slot.
//   A starvation counter forces the host ahead after MAX_WAIT consecutive
//   CPU grants taken while the host was waiting.
//
//   Handshake: a requester raises *_req with stable we/addr/wdata and holds
//   them until it sees *_ack = 1 for one cycle; it drops req on the edge
//   where it samples the ack. Requests are only sampled in IDLE, so one
//   port gets at most one transfer per 3 cycles.
//
//   Ports:
//     clk, reset                : clock, asynchronous active-low reset
//     cpu_* / host_*            : req, we, addr, wdata in; ack, rdata out
//     mem_addr/mem_we/mem_wdata : memory drive, nonzero only in XFER
//     mem_rdata                 : combinational read data from memory
//     dbg_state                 : current FSM state (arb_state_t encoding)
//   Optional (macro DMEM_ARBITER_STATS_EN):
//     cpu_grants, host_grants, host_stall_cycles : saturating counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
`ifdef DMEM_ARBITER_STATS_EN
   ,output logic [15:0]       cpu_grants,
    output logic [15:0]       host_grants,
    output logic [15:0]       host_stall_cycles
`endif
);

    localparam int              WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_MAX = WCW'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    owner_t            owner_q;
    logic              hold_we_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_wdata_q;
    logic [WCW-1:0]    wait_q;

    logic in_idle;
    logic host_win;
    logic grant_host;
    logic grant_cpu;

    assign in_idle    = (state_q == IDLE);
    assign host_win   = host_req && (!cpu_req || (wait_q == WAIT_MAX));
    assign grant_host = in_idle && host_win;
    assign grant_cpu  = in_idle && cpu_req && !host_win;
    assign dbg_state  = state_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req || host_req) state_d = XFER;
            XFER:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Memory strobes decode from the registered state only, so reset
    // (which clears state asynchronously) pulls mem_we low at once and
    // an in-flight write never reaches the memory's commit edge.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        host_ack  = 1'b0;
        if (state_q == XFER) begin
            mem_we    = hold_we_q;
            mem_addr  = hold_addr_q;
            mem_wdata = hold_wdata_q;
        end
        if (state_q == ACK) begin
            cpu_ack  = (owner_q == OWN_CPU);
            host_ack = (owner_q == OWN_HOST);
        end
    end

    // ---------------- hold slot and owner ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else if (grant_host) begin
            owner_q      <= OWN_HOST;
            hold_we_q    <= host_we;
            hold_addr_q  <= host_addr;
            hold_wdata_q <= host_wdata;
        end else if (grant_cpu) begin
            owner_q      <= OWN_CPU;
            hold_we_q    <= cpu_we;
            hold_addr_q  <= cpu_addr;
            hold_wdata_q <= cpu_wdata;
        end
    end

    // ---------------- starvation counter ----------------
    // Counts CPU grants taken while the host is waiting; the host wins
    // outright once it reaches MAX_WAIT. Any IDLE cycle without a host
    // request restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else if (in_idle) begin
            if (!host_req || grant_host)
                wait_q <= '0;
            else if (grant_cpu && (wait_q != WAIT_MAX))
                wait_q <= wait_q + 1'b1;
        end
    end

    // ---------------- read data capture ----------------
    // Each port keeps its last read value until its next read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else if ((state_q == XFER) && !hold_we_q) begin
            if (owner_q == OWN_HOST) host_rdata <= mem_rdata;
            else                     cpu_rdata  <= mem_rdata;
        end
    end

`ifdef DMEM_ARBITER_STATS_EN
    dmem_arb_stats u_stats (
        .clk               (clk),
        .reset             (reset),
        .cpu_grant         (grant_cpu),
        .host_grant        (grant_host),
        .host_stall        (grant_cpu && host_req),
        .cpu_grants        (cpu_grants),
        .host_grants       (host_grants),
        .host_stall_cycles (host_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a 256x8 behavioural memory.
//   Inputs change and outputs are observed on the falling clock edge.
//   Cycle numbering: cycle 0 is the rising edge that samples the request
//   in IDLE; an observation after rising edge k belongs to cycle k+1... so
//   the value "c" reported below is the count of rising edges since the
//   request was set (XFER seen at c=1, ack at c=2 from IDLE).
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [7:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic       cpu_ack, host_ack;
  logic [7:0] cpu_rdata, host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [1:0] dbg_state;
`ifdef DMEM_ARBITER_STATS_EN
  logic [15:0] cpu_grants, host_grants, host_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
`ifdef DMEM_ARBITER_STATS_EN
   ,.cpu_grants        (cpu_grants),
    .host_grants       (host_grants),
    .host_stall_cycles (host_stall_cycles)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One request on one port; returns ack latency, write-strobe stats and
  // how often the other port's ack was seen. Called on a falling edge.
  task automatic access(input bit host, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, output logic [7:0] rdata,
                        output int cycles, output int we_cnt, output int we_cyc,
                        output int other);
    cycles = -1; we_cnt = 0; we_cyc = -1; other = 0; rdata = 8'hxx;
    if (host) begin
      host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = c; end
      if (host ? cpu_ack : host_ack) other++;
      if (host ? host_ack : cpu_ack) begin
        cycles = c;
        rdata  = host ? host_rdata : cpu_rdata;
        break;
      end
    end
    if (host) host_req = 1'b0;
    else      cpu_req  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cpu_at, host_at;
    cpu_we = 1'b0; cpu_addr = 8'h00; host_we = 1'b0; host_addr = 8'h01;
    cpu_req = 1'b1; host_req = 1'b1;
    idle(3);
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack got %0h exp 0", cpu_ack); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_host_ack got %0h exp 0", host_ack); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0h exp 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr got %0h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata got %0h exp 0", mem_wdata); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_cpu_rdata got %0h exp 0", cpu_rdata); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rst_host_rdata got %0h exp 0", host_rdata); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0h exp 0", dbg_state); end
    // release with both requests already pending: CPU first, host next
    reset = 1'b1;
    cpu_at = -1; host_at = -1;
    for (int c = 1; c <= 20 && host_at < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ack) begin if (cpu_at < 0) cpu_at = c; cpu_req = 1'b0; end
      if (host_ack) begin host_at = c; host_req = 1'b0; end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    checks++; if (cpu_at !== 2) begin errors++; $display("FAIL rst_first_cpu_ack got %0d exp 2", cpu_at); end
    checks++; if (host_at !== 5) begin errors++; $display("FAIL rst_then_host_ack got %0d exp 5", host_at); end
  endtask

  task automatic test_cpu_write_read();
    logic [7:0] rd; int cyc, wc, wcy, oth;
    idle(1);
    access(1'b0, 1'b1, 8'h05, 8'hA5, rd, cyc, wc, wcy, oth);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL cpu_wr_lat got %0d exp 2", cyc); end
    checks++; if (wc !== 1 || wcy !== 1) begin errors++; $display("FAIL cpu_wr_we got cnt %0d cyc %0d exp cnt 1 cyc 1", wc, wcy); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL cpu_wr_other_ack got %0d exp 0", oth); end
    checks++; if (mem[8'h05] !== 8'hA5) begin errors++; $display("FAIL cpu_wr_mem got %0h exp a5", mem[8'h05]); end
    // back-to-back read, request presented on the ack cycle
    access(1'b0, 1'b0, 8'h05, 8'h00, rd, cyc, wc, wcy, oth);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL cpu_rd_lat got %0d exp 3", cyc); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL cpu_rd_we got %0d exp 0", wc); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL cpu_rd_data got %0h exp a5", rd); end
    idle(3);
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL cpu_rdata_hold got %0h exp a5", cpu_rdata); end
  endtask

  task automatic test_host_preload();
    logic [7:0] pa [4];
    logic [7:0] pd [4];
    logic [7:0] rd; int cyc, wc, wcy, oth;
    pa = '{8'h01, 8'h02, 8'h03, 8'h04};
    pd = '{8'h03, 8'hFF, 8'hFF, 8'hFB};
    idle(1);
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, pa[i], pd[i], rd, cyc, wc, wcy, oth);
      checks++; if (cyc !== ((i == 0) ? 2 : 3)) begin errors++; $display("FAIL preload_lat[%0d] got %0d exp %0d", i, cyc, (i == 0) ? 2 : 3); end
      checks++; if (wc !== 1 || oth !== 0) begin errors++; $display("FAIL preload_we[%0d] got we %0d other %0d exp 1 0", i, wc, oth); end
    end
    access(1'b0, 1'b0, 8'h04, 8'h00, rd, cyc, wc, wcy, oth);
    checks++; if (rd !== 8'hFB || cyc !== 3) begin errors++; $display("FAIL cpu_read_preload got %0h lat %0d exp fb lat 3", rd, cyc); end
    access(1'b1, 1'b0, 8'h02, 8'h00, rd, cyc, wc, wcy, oth);
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL host_readback got %0h exp ff", rd); end
    checks++; if (cpu_rdata !== 8'hFB) begin errors++; $display("FAIL cpu_rdata_untouched got %0h exp fb", cpu_rdata); end
  endtask

  task automatic test_starvation();
    logic [0:0] got, exp;
    int both = 0;
    idle(2);
    exp_q.delete();
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    cpu_we = 1'b0; cpu_addr = 8'h04; host_we = 1'b0; host_addr = 8'h03;
    cpu_req = 1'b1; host_req = 1'b1;
    for (int c = 1; c <= 60 && exp_q.size() > 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ack && host_ack) both++;
      if (cpu_ack || host_ack) begin
        got = host_ack ? 1'b1 : 1'b0;
        if (host_ack) host_req = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL starve_order got owner %0d exp %0d at cycle %0d", got, exp, c); end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL starve_timeout got %0d acks left exp 0", exp_q.size()); end
    checks++; if (both !== 0) begin errors++; $display("FAIL starve_dual_ack got %0d exp 0", both); end
    checks++; if (cpu_rdata !== 8'hFB || host_rdata !== 8'hFF) begin errors++; $display("FAIL starve_rdata got %0h %0h exp fb ff", cpu_rdata, host_rdata); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [7:0] rd; int cyc, wc, wcy, oth;
    int acks = 0;
    idle(2);
    host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h77; host_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("FAIL midx_in_xfer got we %0h addr %0h exp 1 10", mem_we, mem_addr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midx_we_drop got %0h exp 0", mem_we); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midx_state got %0h exp 0", dbg_state); end
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (host_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midx_no_ack got %0d exp 0", acks); end
    checks++; if (mem[8'h10] !== 8'h00) begin errors++; $display("FAIL midx_mem got %0h exp 0", mem[8'h10]); end
    checks++; if (cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin errors++; $display("FAIL midx_rdata_clr got %0h %0h exp 0 0", cpu_rdata, host_rdata); end
    access(1'b0, 1'b0, 8'h10, 8'h00, rd, cyc, wc, wcy, oth);
    checks++; if (rd !== 8'h00 || cyc !== 2) begin errors++; $display("FAIL midx_readback got %0h lat %0d exp 0 lat 2", rd, cyc); end
  endtask

`ifdef DMEM_ARBITER_STATS_EN
  task automatic test_stats();
    logic [7:0] rd; int cyc, wc, wcy, oth;
    int host_at = -1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (cpu_grants !== 16'd0 || host_grants !== 16'd0 || host_stall_cycles !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d %0d %0d exp 0 0 0", cpu_grants, host_grants, host_stall_cycles); end
    access(1'b0, 1'b0, 8'h01, 8'h00, rd, cyc, wc, wcy, oth);
    access(1'b0, 1'b0, 8'h02, 8'h00, rd, cyc, wc, wcy, oth);
    idle(1);
    cpu_we = 1'b0; cpu_addr = 8'h03; host_we = 1'b0; host_addr = 8'h04;
    cpu_req = 1'b1; host_req = 1'b1;
    for (int c = 1; c <= 20 && host_at < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ack) cpu_req = 1'b0;
      if (host_ack) begin host_at = c; host_req = 1'b0; end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    idle(1);
    checks++; if (host_at !== 5) begin errors++; $display("FAIL stats_host_lat got %0d exp 5", host_at); end
    checks++; if (cpu_grants !== 16'd3) begin errors++; $display("FAIL stats_cpu_grants got %0d exp 3", cpu_grants); end
    checks++; if (host_grants !== 16'd1) begin errors++; $display("FAIL stats_host_grants got %0d exp 1", host_grants); end
    checks++; if (host_stall_cycles !== 16'd1) begin errors++; $display("FAIL stats_host_stall got %0d exp 1", host_stall_cycles); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    @(negedge clk);
    test_reset();
    test_cpu_write_read();
    test_host_preload();
    test_starvation();
    test_reset_mid_xfer();
`ifdef DMEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
